xconf_bank: RTL and testbench
=============================

Name: xconf_bank

Overview:
- Parametrised successor to the fixed-layout configuration register.
- Holds N_FIELDS uniform config fields in a shadow register written over the control bus, plus an active register that drives the datapath.
- Active register changes only on a commit, which is deferred while the engine runs.
- Adds NUM_SLOTS on-chip context slots: the whole shadow is saved to, or loaded from, a slot by a multi-cycle copy FSM.

Parameters:
- N_FIELDS, 16, number of config fields.
- FIELD_W, 16, width of each field in bits. Must satisfy FIELD_W <= DATA_W.
- NUM_SLOTS, 4, number of saved context slots. Must be >= 1.
- ADDR_W, 8, control address width. Must satisfy N_FIELDS+5 <= 2**ADDR_W.
- DATA_W, 32, control data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; asserted when 0.
- ctr_valid  in  1  request valid.
- ctr_ready  out  1  request accepted when ctr_valid & ctr_ready.
- ctr_we  in  1  1 = write, 0 = read.
- ctr_addr  in  ADDR_W  field or command address.
- ctr_data_in  in  DATA_W  write data.
- ctr_data_out  out  DATA_W  read data.
- engine_busy  in  1  datapath is running.
- conf_out  out  N_FIELDS*FIELD_W  active config; field i at bits [(i+1)*FIELD_W-1 : i*FIELD_W].
- conf_update  out  1  one-cycle pulse in the cycle after active was loaded.
- commit_pending  out  1  a commit is waiting to be applied.

Behaviour:
- Reset (rst==0 at a clk edge):
  - shadow = 0, active = 0 (so conf_out = 0).
  - FSM = IDLE, commit_pending = 0, conf_update = 0, ctr_data_out = 0.
  - Slot memory is not reset.
  - Reset mid-SAVE or mid-LOAD aborts the copy. Slot contents already written remain.
- Handshake:
  - ctr_ready = (state == IDLE), combinational.
  - A request is accepted only when ctr_valid & ctr_ready. The master holds the request while ready is low.
- Address map:
  - 0..N_FIELDS-1: field i.
  - N_FIELDS+0: CLEAR.
  - N_FIELDS+1: COMMIT.
  - N_FIELDS+2: SAVE (slot number in ctr_data_in).
  - N_FIELDS+3: LOAD (slot number in ctr_data_in).
  - N_FIELDS+4: STATUS (read only).
  - All other addresses: writes ignored, reads return 0.
- Field write: shadow[i] <= ctr_data_in[FIELD_W-1:0] at the accepting edge. Active and conf_out are unchanged.
- Read:
  - ctr_data_out is registered with 1-cycle latency and holds until the next read.
  - Field read returns shadow[i], zero-extended.
  - STATUS read returns bit0 = (state != IDLE), bit1 = commit_pending; other bits 0.
  - A read of a command address returns 0.
- CLEAR: shadow <= 0. Active is unaffected.
- COMMIT:
  - If engine_busy==0 in the accept cycle: active <= shadow at that edge, and conf_update = 1 in the following cycle.
  - If engine_busy==1: commit_pending <= 1.
  - A pending commit is applied at the first edge where engine_busy==0 and state==IDLE. It copies the shadow value at that edge, clears pending, and pulses conf_update in the next cycle.
  - A COMMIT accepted while pending is already set is merged; no extra pulse.
  - Field writes made while pending are included in the eventual commit.
- SAVE slot s:
  - If s >= NUM_SLOTS, the request is ignored and the FSM stays IDLE.
  - Otherwise the FSM goes IDLE->SAVE. On cycle k (k = 0..N_FIELDS-1) it writes mem[s*N_FIELDS+k] <= shadow[k], then returns to IDLE.
  - ctr_ready is low for exactly N_FIELDS cycles after the accepting edge.
- LOAD slot s:
  - Out-of-range s is ignored.
  - Otherwise IDLE->LOAD. Memory read latency is 1 cycle, so mem[s*N_FIELDS+k] lands in shadow[k] one cycle after its address is issued.
  - ctr_ready is low for N_FIELDS+1 cycles.
  - Pending commits are not applied during LOAD or SAVE, so active never sees a partial shadow.
- Field index counter: width clog2(N_FIELDS). Slot base is s*N_FIELDS, computed in clog2(NUM_SLOTS*N_FIELDS) bits, with no wrap.
- engine_busy does not block any control access.

Decomposition:
- Package xconf_bank_pkg contains:
  - command offsets: CLEAR=0, COMMIT=1, SAVE=2, LOAD=3, STATUS=4, all relative to N_FIELDS;
  - FSM state encoding: IDLE, SAVE, LOAD;
  - STATUS bit positions.
- Sub-module xconf_slot_mem: single-port synchronous RAM, depth NUM_SLOTS*N_FIELDS, width FIELD_W, 1-cycle read latency, no reset.
- Everything else (FSM, shadow, active, commit logic) lives in xconf_bank.

Test Plan:
- Write 0xAAAA to field 0 and 0x1234 to field 5, engine_busy=0; COMMIT -> conf_out field0=0xAAAA and field5=0x1234 in the cycle after accept; conf_update high for exactly 1 cycle; a read of field 5 returns 0x1234 one cycle after accept.
- engine_busy=1; write field 2 = 0x00FF; COMMIT; write field 2 = 0x0F0F -> commit_pending=1 and conf_out field2 unchanged; drop engine_busy -> field2=0x0F0F, one conf_update pulse, pending=0; a second COMMIT issued while pending produces no second pulse.
- Fill fields with values 0x100+i; SAVE slot 2 -> ready low 16 cycles; CLEAR, then LOAD 2 -> ready low 17 cycles, all fields read 0x100+i; LOAD 7 (out of range) -> ready stays high and shadow is unchanged.
- Pending commit set, then LOAD issued; engine_busy drops mid-LOAD -> active is loaded only at the first IDLE cycle, with the complete loaded shadow.
- rst=0 during LOAD cycle 5 -> the next cycle shows shadow=0, conf_out=0, ctr_ready=1, commit_pending=0; STATUS reads 0.
- Write to address N_FIELDS+9 and read it -> no state change, read returns 0.

Source files
------------

// File: rtl/xconf_bank_pkg.sv
// Shared constants for the xconf_bank configuration block.
//   - Command offsets, relative to N_FIELDS in the control address map.
//   - Copy-FSM state encoding.
//   - STATUS read bit positions.
//   - Address-width helper.
package xconf_bank_pkg;

  localparam int unsigned CMD_CLEAR  = 0;
  localparam int unsigned CMD_COMMIT = 1;
  localparam int unsigned CMD_SAVE   = 2;
  localparam int unsigned CMD_LOAD   = 3;
  localparam int unsigned CMD_STATUS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SAVE = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_PENDING = 1;

  // clog2 that never returns 0, so that single-entry ranges still get a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xconf_bank_if.sv
// Control-bus interface for xconf_bank.
//   ctr_valid/ctr_ready : request handshake, accepted when both are high.
//   ctr_we              : 1 = write, 0 = read.
//   ctr_addr            : field or command address.
//   ctr_data_in         : write data.
//   ctr_data_out        : registered read data.
interface xconf_bank_if
  import xconf_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              ctr_valid;
  logic              ctr_ready;
  logic              ctr_we;
  logic [ADDR_W-1:0] ctr_addr;
  logic [DATA_W-1:0] ctr_data_in;
  logic [DATA_W-1:0] ctr_data_out;

  modport master (output ctr_valid, ctr_we, ctr_addr, ctr_data_in,
                  input  ctr_ready, ctr_data_out);
  modport slave  (input  ctr_valid, ctr_we, ctr_addr, ctr_data_in,
                  output ctr_ready, ctr_data_out);
endinterface

// File: rtl/xconf_slot_mem.sv
// Context-slot storage: single-port synchronous RAM with 1-cycle read latency, no reset.
//   clk     : clock.
//   i_we    : write enable.
//   i_addr  : word address (read and write share it).
//   i_wdata : write data.
//   o_rdata : data at the address presented in the previous cycle.
module xconf_slot_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/xconf_bank.sv
// Configuration bank: a shadow register written over the control bus, an active register
// that drives the datapath, deferred commit while the engine runs, and save/load of the
// whole shadow to on-chip context slots.
//   clk, rst       : clock, synchronous active-low reset.
//   bus            : control bus (slave side).
//   engine_busy    : datapath running; defers commits.
//   conf_out       : active config, field i at [(i+1)*FIELD_W-1 : i*FIELD_W].
//   conf_update    : one-cycle pulse after active was loaded.
//   commit_pending : a deferred commit is waiting.
module xconf_bank
  import xconf_bank_pkg::*;
#(
  parameter int unsigned N_FIELDS  = 16,
  parameter int unsigned FIELD_W   = 16,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  xconf_bank_if.slave                 bus,
  input  logic                        engine_busy,
  output logic [N_FIELDS*FIELD_W-1:0] conf_out,
  output logic                        conf_update,
  output logic                        commit_pending
);
  localparam int unsigned IDX_W  = clog2_min1(N_FIELDS);
  localparam int unsigned MEM_D  = NUM_SLOTS * N_FIELDS;
  localparam int unsigned MEM_AW = clog2_min1(MEM_D);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [MEM_AW-1:0] r_base;
  logic              r_issue_done;
  logic              r_rd_pend;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_pending;
  logic              r_update;
  logic [DATA_W-1:0] r_rdata;
  logic [FIELD_W-1:0] r_shadow [N_FIELDS];
  logic [FIELD_W-1:0] r_active [N_FIELDS];

  logic              w_ready, w_accept, w_wr, w_rd, w_is_field;
  logic              w_commit, w_clear, w_save, w_load, w_slot_ok, w_apply;
  logic [IDX_W-1:0]  w_fidx;
  logic [MEM_AW-1:0] w_base;
  logic [DATA_W-1:0] w_rd_val;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [FIELD_W-1:0] w_mem_rdata;

  always_comb begin
    w_ready    = (r_state == ST_IDLE);
    w_accept   = bus.ctr_valid & w_ready;
    w_wr       = w_accept & bus.ctr_we;
    w_rd       = w_accept & ~bus.ctr_we;
    w_is_field = (bus.ctr_addr < ADDR_W'(N_FIELDS));
    w_fidx     = IDX_W'(bus.ctr_addr);
    w_slot_ok  = (bus.ctr_data_in < DATA_W'(NUM_SLOTS));
    w_base     = MEM_AW'(bus.ctr_data_in * DATA_W'(N_FIELDS));
    w_clear    = w_wr & (bus.ctr_addr == ADDR_W'(N_FIELDS + CMD_CLEAR));
    w_commit   = w_wr & (bus.ctr_addr == ADDR_W'(N_FIELDS + CMD_COMMIT));
    w_save     = w_wr & (bus.ctr_addr == ADDR_W'(N_FIELDS + CMD_SAVE)) & w_slot_ok;
    w_load     = w_wr & (bus.ctr_addr == ADDR_W'(N_FIELDS + CMD_LOAD)) & w_slot_ok;
    // A fresh COMMIT and an already pending one collapse into one apply, hence one pulse.
    w_apply    = w_ready & ~engine_busy & (r_pending | w_commit);

    w_rd_val = '0;
    if (w_is_field) begin
      w_rd_val = DATA_W'(r_shadow[w_fidx]);
    end else if (bus.ctr_addr == ADDR_W'(N_FIELDS + CMD_STATUS)) begin
      w_rd_val[STAT_BUSY]    = (r_state != ST_IDLE);
      w_rd_val[STAT_PENDING] = r_pending;
    end

    w_mem_addr = r_base + MEM_AW'(r_idx);
  end

  xconf_slot_mem #(.DEPTH(MEM_D), .WIDTH(FIELD_W), .AW(MEM_AW)) u_mem (
    .clk     (clk),
    .i_we    (r_state == ST_SAVE),
    .i_addr  (w_mem_addr),
    .i_wdata (r_shadow[r_idx]),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_base       <= '0;
      r_issue_done <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_idx     <= '0;
      r_pending    <= 1'b0;
      r_update     <= 1'b0;
      r_rdata      <= '0;
      r_shadow     <= '{default: '0};
      r_active     <= '{default: '0};
    end else begin
      r_update  <= w_apply;
      r_rd_pend <= 1'b0;
      if (w_apply) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (w_commit) begin
        r_pending <= 1'b1;
      end
      if (w_rd) r_rdata <= w_rd_val;

      case (r_state)
        ST_IDLE: begin
          if (w_wr & w_is_field) begin
            r_shadow[w_fidx] <= bus.ctr_data_in[FIELD_W-1:0];
          end else if (w_clear) begin
            r_shadow <= '{default: '0};
          end else if (w_save | w_load) begin
            r_state      <= w_save ? ST_SAVE : ST_LOAD;
            r_idx        <= '0;
            r_base       <= w_base;
            r_issue_done <= 1'b0;
          end
        end
        ST_SAVE: begin
          if (r_idx == IDX_W'(N_FIELDS - 1)) begin
            r_idx   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_LOAD: begin
          // Addresses are issued for N_FIELDS cycles; one extra cycle drains the last read.
          if (!r_issue_done) begin
            r_rd_pend <= 1'b1;
            r_rd_idx  <= r_idx;
            if (r_idx == IDX_W'(N_FIELDS - 1)) begin
              r_issue_done <= 1'b1;
              r_idx        <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (r_rd_pend) r_shadow[r_rd_idx] <= w_mem_rdata;
    end
  end

  always_comb begin
    conf_out = '0;
    for (int unsigned i = 0; i < N_FIELDS; i++) begin
      conf_out[i*FIELD_W +: FIELD_W] = r_active[i];
    end
  end

  assign bus.ctr_ready    = w_ready;
  assign bus.ctr_data_out = r_rdata;
  assign conf_update      = r_update;
  assign commit_pending   = r_pending;
endmodule

// File: tb/tb_xconf_bank.sv
module tb_xconf_bank;
  localparam int NF = 16;
  localparam int FW = 16;
  localparam int NS = 4;
  localparam logic [7:0] A_CLEAR = 8'd16, A_COMMIT = 8'd17, A_SAVE = 8'd18,
                         A_LOAD = 8'd19, A_STATUS = 8'd20, A_BAD = 8'd25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic engine_busy = 1'b0;
  logic [NF*FW-1:0] conf_out;
  logic conf_update, commit_pending;

  xconf_bank_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  xconf_bank #(.N_FIELDS(NF), .FIELD_W(FW), .NUM_SLOTS(NS), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .engine_busy(engine_busy),
    .conf_out(conf_out), .conf_update(conf_update), .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  task automatic check(input string name, input logic [NF*FW-1:0] act, input logic [NF*FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: whole-register copies and a busy countdown, no FSM detail.
  logic [FW-1:0] m_shadow [NF];
  logic [FW-1:0] m_active [NF];
  logic [FW-1:0] m_slots  [NS][NF];
  logic          m_pending = 1'b0, m_upd = 1'b0, m_init = 1'b0;
  logic [31:0]   m_rdata = '0;
  int            m_busy_left = 0;

  always @(posedge clk) begin
    logic acc, cmt, app;
    if (!rst) begin
      m_init <= 1'b1; m_pending <= 1'b0; m_upd <= 1'b0; m_rdata <= '0; m_busy_left <= 0;
      for (int i = 0; i < NF; i++) begin m_shadow[i] <= '0; m_active[i] <= '0; end
    end else begin
      acc = bus.ctr_valid && (m_busy_left == 0);
      cmt = acc && bus.ctr_we && (bus.ctr_addr == A_COMMIT);
      app = (m_busy_left == 0) && !engine_busy && (m_pending || cmt);
      m_upd <= app;
      if (app) begin
        for (int i = 0; i < NF; i++) m_active[i] <= m_shadow[i];
        m_pending <= 1'b0;
      end else if (cmt) m_pending <= 1'b1;
      if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
      if (acc && bus.ctr_we) begin
        if (bus.ctr_addr < NF) m_shadow[bus.ctr_addr] <= bus.ctr_data_in[FW-1:0];
        else if (bus.ctr_addr == A_CLEAR)
          for (int i = 0; i < NF; i++) m_shadow[i] <= '0;
        else if (bus.ctr_addr == A_SAVE && bus.ctr_data_in < NS) begin
          for (int i = 0; i < NF; i++) m_slots[bus.ctr_data_in][i] <= m_shadow[i];
          m_busy_left <= NF;
        end else if (bus.ctr_addr == A_LOAD && bus.ctr_data_in < NS) begin
          for (int i = 0; i < NF; i++) m_shadow[i] <= m_slots[bus.ctr_data_in][i];
          m_busy_left <= NF + 1;
        end
      end
      if (acc && !bus.ctr_we) begin
        if (bus.ctr_addr < NF) m_rdata <= 32'(m_shadow[bus.ctr_addr]);
        else if (bus.ctr_addr == A_STATUS) m_rdata <= {30'd0, m_pending, 1'b0};
        else m_rdata <= '0;
      end
    end
  end

  function automatic logic [NF*FW-1:0] model_conf();
    logic [NF*FW-1:0] v;
    for (int i = 0; i < NF; i++) v[i*FW +: FW] = m_active[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (conf_update === 1'b1) pulses++;
    if (m_init) begin
      check("conf_out",       conf_out,                      model_conf());
      check("conf_update",    (NF*FW)'(conf_update),         (NF*FW)'(m_upd));
      check("commit_pending", (NF*FW)'(commit_pending),      (NF*FW)'(m_pending));
      check("ctr_ready",      (NF*FW)'(bus.ctr_ready),       (NF*FW)'(m_busy_left == 0));
      check("ctr_data_out",   (NF*FW)'(bus.ctr_data_out),    (NF*FW)'(m_rdata));
    end
  end

  // Returns #1 after the accepting edge.
  task automatic op(input logic we, input logic [7:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    bus.ctr_valid = 1'b1; bus.ctr_we = we; bus.ctr_addr = a; bus.ctr_data_in = d;
    while (!bus.ctr_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout addr %0d got no ready expected ready", a);
    end
    @(posedge clk); #1;
    bus.ctr_valid = 1'b0;
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!bus.ctr_ready && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  function automatic logic [FW-1:0] fld(input int i);
    return conf_out[i*FW +: FW];
  endfunction

  int n, p0;

  initial begin
    bus.ctr_valid = 1'b0; bus.ctr_we = 1'b0; bus.ctr_addr = '0; bus.ctr_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_conf_out", conf_out, '0);
    check("rst_ready", (NF*FW)'(bus.ctr_ready), 1);
    check("rst_pending", (NF*FW)'(commit_pending), 0);
    check("rst_data_out", (NF*FW)'(bus.ctr_data_out), 0);

    // Immediate commit
    op(1, 0, 32'hAAAA);
    op(1, 5, 32'h1234);
    check("pre_commit_f0", (NF*FW)'(fld(0)), 0);
    op(1, A_COMMIT, 0);
    check("commit_f0", (NF*FW)'(fld(0)), 16'hAAAA);
    check("commit_f5", (NF*FW)'(fld(5)), 16'h1234);
    check("commit_pulse", (NF*FW)'(conf_update), 1);
    @(posedge clk); #1;
    check("commit_pulse_end", (NF*FW)'(conf_update), 0);
    op(0, 5, 0);
    check("read_f5", (NF*FW)'(bus.ctr_data_out), 16'h1234);

    // Deferred commit while the engine runs
    engine_busy = 1'b1;
    op(1, 2, 32'h00FF);
    op(1, A_COMMIT, 0);
    op(1, 2, 32'h0F0F);
    check("defer_pending", (NF*FW)'(commit_pending), 1);
    check("defer_f2_hold", (NF*FW)'(fld(2)), 0);
    op(0, A_STATUS, 0);
    check("status_pending", (NF*FW)'(bus.ctr_data_out), 2);
    p0 = pulses;
    op(1, A_COMMIT, 0);
    engine_busy = 1'b0;
    @(posedge clk); #1;
    check("defer_f2", (NF*FW)'(fld(2)), 16'h0F0F);
    check("defer_pending_clr", (NF*FW)'(commit_pending), 0);
    repeat (3) @(posedge clk);
    #1 check("defer_one_pulse", (NF*FW)'(pulses - p0), 1);

    // Save / clear / load
    for (int i = 0; i < NF; i++) op(1, 8'(i), 32'h100 + i);
    op(1, A_SAVE, 2);
    count_low(n);
    check("save_ready_low", (NF*FW)'(n), 16);
    op(1, A_CLEAR, 0);
    op(0, 3, 0);
    check("clear_f3", (NF*FW)'(bus.ctr_data_out), 0);
    op(1, A_LOAD, 2);
    count_low(n);
    check("load_ready_low", (NF*FW)'(n), 17);
    for (int i = 0; i < NF; i++) begin
      op(0, 8'(i), 0);
      check("load_field", (NF*FW)'(bus.ctr_data_out), (NF*FW)'(32'h100 + i));
    end
    op(1, 4, 32'h0444);
    op(1, A_LOAD, 7);
    check("load_oob_ready", (NF*FW)'(bus.ctr_ready), 1);
    op(0, 4, 0);
    check("load_oob_f4", (NF*FW)'(bus.ctr_data_out), 16'h0444);

    // Pending commit held back across a LOAD
    engine_busy = 1'b1;
    op(1, 7, 32'h0377);
    op(1, A_COMMIT, 0);
    op(1, A_LOAD, 2);
    repeat (5) @(posedge clk);
    #1 engine_busy = 1'b0;
    check("midload_f7_hold", (NF*FW)'(fld(7)), 0);
    count_low(n);
    check("midload_still_pending", (NF*FW)'(commit_pending), 1);
    @(posedge clk); #1;
    check("afterload_f7", (NF*FW)'(fld(7)), 16'h0107);
    check("afterload_f4", (NF*FW)'(fld(4)), 16'h0104);
    check("afterload_pulse", (NF*FW)'(conf_update), 1);

    // Reset in the middle of a LOAD
    engine_busy = 1'b1;
    op(1, A_COMMIT, 0);
    op(1, A_LOAD, 2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; engine_busy = 1'b0;
    check("rstload_conf", conf_out, '0);
    check("rstload_ready", (NF*FW)'(bus.ctr_ready), 1);
    check("rstload_pending", (NF*FW)'(commit_pending), 0);
    op(0, A_STATUS, 0);
    check("rstload_status", (NF*FW)'(bus.ctr_data_out), 0);
    op(0, 9, 0);
    check("rstload_f9", (NF*FW)'(bus.ctr_data_out), 0);

    // Unmapped address
    op(1, 1, 32'h5A5A);
    op(1, A_BAD, 32'hDEAD);
    op(0, A_BAD, 0);
    check("bad_read", (NF*FW)'(bus.ctr_data_out), 0);
    op(0, 1, 0);
    check("bad_no_effect", (NF*FW)'(bus.ctr_data_out), 16'h5A5A);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
